// File: rtl/ysyx_23060201_lsu.sv
// Multi-cycle load/store unit: turns one execute-stage memory request into a
// valid/ready word-bus transaction and returns formatted load data to write-back.
module ysyx_23060201_lsu #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_ren,
  input  logic [MEM_ADDR_WIDTH-1:0] in_raddr,
  input  logic [7:0]                in_rmask,
  input  logic                      in_wen,
  input  logic [MEM_ADDR_WIDTH-1:0] in_waddr,
  input  logic [7:0]                in_wmask,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic                      req_we,
  output logic [MEM_ADDR_WIDTH-1:0] req_addr,
  output logic [3:0]                req_wstrb,
  output logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      resp_valid,
  output logic                      resp_ready,
  input  logic [DATA_WIDTH-1:0]     resp_rdata,
  input  logic                      resp_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_rdata,
  output logic                      out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, next_state;

  logic [MEM_ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]                sel_off;
  logic [3:0]                acc_size;
  logic                      rd_mask_ok;
  logic                      wr_mask_ok;
  logic                      misaligned;
  logic                      req_err;
  logic                      is_noop;
  logic [3:0]                st_strb;
  logic [DATA_WIDTH-1:0]     st_data;

  logic [4:0]                ld_kind;
  logic [1:0]                ld_off;

  // ld_kind is {sign-extend, size nibble}; the nibble is 1/3/F for byte/half/word.
  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            off,
    input logic [4:0]            kind
  );
    logic [DATA_WIDTH-1:0] w;
    w = raw >> {off, 3'b000};
    case (kind[3:0])
      4'h1:    format_load = {{24{kind[4] & w[7]}}, w[7:0]};
      4'h3:    format_load = {{16{kind[4] & w[15]}}, w[15:0]};
      default: format_load = w;
    endcase
  endfunction

  // Request decode; only feeds register updates and next-state, never an output.
  always_comb begin
    sel_addr = in_ren ? in_raddr : in_waddr;
    sel_off  = sel_addr[1:0];
    acc_size = in_ren ? in_rmask[3:0] : in_wmask[3:0];

    rd_mask_ok = 1'b0;
    case (in_rmask)
      8'h11, 8'h13, 8'h1F, 8'h01, 8'h03: rd_mask_ok = 1'b1;
      default:                           rd_mask_ok = 1'b0;
    endcase

    wr_mask_ok = 1'b0;
    case (in_wmask)
      8'h01, 8'h03, 8'h0F: wr_mask_ok = 1'b1;
      default:             wr_mask_ok = 1'b0;
    endcase

    misaligned = ((acc_size == 4'h3) && sel_off[0]) ||
                 ((acc_size == 4'hF) && (sel_off != 2'b00));

    is_noop = !in_ren && !in_wen;
    req_err = (in_ren && in_wen) ||
              (in_ren && !rd_mask_ok) ||
              (in_wen && !wr_mask_ok) ||
              (!is_noop && misaligned);

    case (in_wmask[3:0])
      4'h1:    st_strb = 4'b0001 << sel_off;
      4'h3:    st_strb = 4'b0011 << sel_off;
      default: st_strb = 4'b1111;
    endcase

    case (in_wmask[3:0])
      4'h1:    st_data = {4{in_wdata[7:0]}};
      4'h3:    st_data = {2{in_wdata[15:0]}};
      default: st_data = in_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)   next_state = (req_err || is_noop) ? DONE : REQ;
      REQ:  if (req_ready)  next_state = WAIT;
      WAIT: if (resp_valid) next_state = DONE;
      DONE: if (out_ready)  next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    req_valid  = (state == REQ);
    resp_ready = (state == WAIT);
    out_valid  = (state == DONE);
  end

  // Bus fields are only loaded on the way into REQ so they hold until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wstrb <= 4'b0000;
      req_wdata <= '0;
      ld_kind   <= 5'b0;
      ld_off    <= 2'b00;
      out_rdata <= '0;
      out_err   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      out_rdata <= '0;
      out_err   <= req_err;
      if (!req_err && !is_noop) begin
        req_we    <= in_wen;
        req_addr  <= {sel_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
        req_wstrb <= in_wen ? st_strb : 4'b0000;
        req_wdata <= in_wen ? st_data : '0;
        ld_kind   <= in_rmask[4:0];
        ld_off    <= sel_off;
      end
    end else if (state == WAIT && resp_valid) begin
      out_err   <= resp_err;
      out_rdata <= (resp_err || req_we) ? '0 : format_load(resp_rdata, ld_off, ld_kind);
    end
  end

endmodule
